// File: rtl/or1200_vlx_pkg.sv
// Shared definitions for the OR1200 VLX bit packer.
// Holds the flush state encoding, the SPR address map and the
// byte constants used for JPEG marker stuffing and final-byte padding.
package or1200_vlx_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAD   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic       SPR_ADDR_CNT = 1'b0;
  localparam logic       SPR_ADDR_ACC = 1'b1;

  localparam logic [7:0] STUFF_BYTE  = 8'h00;
  localparam logic [7:0] MARKER_BYTE = 8'hFF;
  localparam logic       PAD_BIT     = 1'b1;

endpackage

// File: rtl/or1200_vlx_fifo.sv
// Synchronous byte FIFO between the packer and the byte consumer.
// Ports:
//   clk_i, rst_n_i    clock, asynchronous active-low reset
//   push_i, din_i     write strobe and data (ignored when full unless popping)
//   pop_i             read strobe (ignored when empty)
//   dout_o            head entry
//   full_o, empty_o   occupancy flags
//   count_o           number of stored entries
module or1200_vlx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [7:0]               din_i,
  input  logic                     pop_i,
  output logic [7:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count == '0);
  assign full_o  = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem[rd_ptr];
  assign count_o = count;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/or1200_vlx_packer.sv
// JPEG entropy-coder bit packer for the OR1200 VLX datapath.
// Codes enter MSB-first into a left-aligned accumulator; whole bytes are
// moved into a byte FIFO, with optional 0x00 stuffing after 0xFF and
// 1-padding of the last partial byte on flush.
// Ports:
//   clk_i, rst_n_i                     clock, asynchronous active-low reset
//   code_i, size_i, code_valid_i,
//   code_ready_o                       code input handshake
//   stuff_en_i                         insert 0x00 after each emitted 0xFF
//   flush_i, done_o                    flush request / drain-complete pulse
//   byte_o, byte_valid_o, byte_ready_i byte output handshake
//   spr_we_i, spr_addr_i, spr_dat_i,
//   spr_dat_o                          bit count / accumulator SPR access
//   busy_o                             packer holds data or is flushing
//
// state | meaning
// RUN   | accept codes, extract bytes
// PAD   | fill to the next byte boundary with 1s
// DRAIN | extract remaining bytes, wait for FIFO empty
// DONE  | one-cycle done pulse, back to RUN
module or1200_vlx_packer
  import or1200_vlx_pkg::*;
#(
  parameter int ACC_W      = 32,
  parameter int MAX_CODE_W = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(ACC_W+1)
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [MAX_CODE_W-1:0]         code_i,
  input  logic [$clog2(MAX_CODE_W+1)-1:0] size_i,
  input  logic                          code_valid_i,
  output logic                          code_ready_o,
  input  logic                          stuff_en_i,
  input  logic                          flush_i,
  output logic                          done_o,
  output logic [7:0]                    byte_o,
  output logic                          byte_valid_o,
  input  logic                          byte_ready_i,
  input  logic                          spr_we_i,
  input  logic                          spr_addr_i,
  input  logic [31:0]                   spr_dat_i,
  output logic [31:0]                   spr_dat_o,
  output logic                          busy_o
);

  localparam int SZ_W = $clog2(MAX_CODE_W+1);

  state_t             state;
  logic [ACC_W-1:0]   acc, acc_sh, acc_nx, code_ext, pad_mask;
  logic [CNT_W-1:0]   bit_cnt, cnt_sh, cnt_nx, cnt_wr;
  logic               stuff_pending;
  logic [MAX_CODE_W:0] size_mask;
  logic [ACC_W+31:0]  acc_rd_pad, dat_wr_pad;
  int                 rnd;

  logic               fifo_full, fifo_empty, fifo_push, fifo_pop, room;
  logic [7:0]         fifo_din, fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic               spr_take, ext, stuff_push, accept;

  // SPR writes only land while idle; they take the cycle exclusively.
  assign spr_take     = spr_we_i && (state == RUN) && fifo_empty;
  assign code_ready_o = (state == RUN) && !spr_take &&
                        (int'(bit_cnt) + MAX_CODE_W <= ACC_W);
  assign accept       = code_valid_i && code_ready_o;

  assign fifo_pop     = byte_valid_o && byte_ready_i;
  assign room         = !fifo_full || fifo_pop;
  assign stuff_push   = stuff_pending && room;
  assign ext          = !spr_take && (state != DONE) && !stuff_pending &&
                        (bit_cnt >= CNT_W'(8)) && room;
  assign fifo_push    = stuff_push || ext;
  assign fifo_din     = stuff_push ? STUFF_BYTE : acc[ACC_W-1 -: 8];

  assign size_mask = ((MAX_CODE_W+1)'(1) << size_i) - (MAX_CODE_W+1)'(1);
  assign code_ext  = ACC_W'(code_i & size_mask[MAX_CODE_W-1:0]);

  // Byte shift first, then the new code lands at the post-shift fill level.
  always_comb begin
    acc_sh = acc;
    cnt_sh = bit_cnt;
    if (ext) begin
      acc_sh = acc << 8;
      cnt_sh = bit_cnt - CNT_W'(8);
    end
    acc_nx = acc_sh;
    cnt_nx = cnt_sh;
    if (accept) begin
      acc_nx = acc_sh | (code_ext << (ACC_W - int'(cnt_sh) - int'(SZ_W'(size_i))));
      cnt_nx = cnt_sh + CNT_W'(size_i);
    end
    rnd      = ((int'(cnt_sh) + 7) / 8) * 8;
    pad_mask = ~({ACC_W{1'b1}} >> rnd) & ({ACC_W{1'b1}} >> cnt_sh);
    if (state == PAD) begin
      acc_nx = PAD_BIT ? (acc_nx | pad_mask) : (acc_nx & ~pad_mask);
      cnt_nx = CNT_W'(rnd);
    end
  end

  assign cnt_wr     = (spr_dat_i[CNT_W-1:0] > CNT_W'(ACC_W)) ? CNT_W'(ACC_W)
                                                             : spr_dat_i[CNT_W-1:0];
  assign dat_wr_pad = {spr_dat_i, {ACC_W{1'b0}}};
  assign acc_rd_pad = {acc, 32'h0};
  assign spr_dat_o  = (spr_addr_i == SPR_ADDR_ACC) ? acc_rd_pad[ACC_W+31 -: 32]
                                                   : 32'(bit_cnt);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= RUN;
      acc           <= '0;
      bit_cnt       <= '0;
      stuff_pending <= 1'b0;
    end else begin
      if (spr_take) begin
        if (spr_addr_i == SPR_ADDR_CNT) bit_cnt <= cnt_wr;
        else                            acc     <= dat_wr_pad[ACC_W+31 -: ACC_W];
      end else begin
        acc     <= acc_nx;
        bit_cnt <= cnt_nx;
      end

      if (stuff_push)                                         stuff_pending <= 1'b0;
      else if (ext && fifo_din == MARKER_BYTE && stuff_en_i)  stuff_pending <= 1'b1;

      case (state)
        RUN:     if (flush_i) state <= PAD;
        PAD:     state <= DRAIN;
        DRAIN:   if (bit_cnt == '0 && !stuff_pending && fifo_empty) state <= DONE;
        DONE:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  or1200_vlx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign byte_valid_o = !fifo_empty;
  assign byte_o       = fifo_empty ? 8'h00 : fifo_dout;
  assign done_o       = (state == DONE);
  assign busy_o       = (state != RUN) || (bit_cnt != '0) || !fifo_empty || stuff_pending;

endmodule

// File: doc/or1200_vlx_packer.md
# or1200_vlx_packer

Parametrised JPEG entropy-coder bit packer for the OR1200 VLX custom-instruction datapath. It accepts variable-length Huffman codes MSB-first, packs them into a left-aligned accumulator and emits whole bytes into an internal byte FIFO. It applies JPEG 0xFF→0xFF,0x00 byte stuffing when enabled, and pads the final byte with 1s on flush. Compared with the previous packer it adds a configurable accumulator/code width, a decoupled valid/ready byte output with buffering, and an explicit flush/done sequence.

## Interface
Parameters:
- ACC_W, 32, accumulator width in bits; ≥ MAX_CODE_W+8, multiple of 8
- MAX_CODE_W, 16, widest code accepted per transfer
- FIFO_DEPTH, 4, byte FIFO entries; power of 2, ≥2
- CNT_W, $clog2(ACC_W+1), width of bit counter

Ports (clock and reset first):
- clk_i  in  1  single clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- code_i  in  MAX_CODE_W  code, right-aligned, bits above size_i ignored (masked internally)
- size_i  in  $clog2(MAX_CODE_W+1)  code length, 0..MAX_CODE_W; 0 accepted as no-op
- code_valid_i  in  1  code transfer request
- code_ready_o  out  1  packer can accept code this cycle
- stuff_en_i  in  1  enable 0x00 insertion after every emitted 0xFF (sampled per byte)
- flush_i  in  1  single-cycle request: pad and drain, accepted only in RUN
- done_o  out  1  one-cycle pulse when flush has fully drained FIFO
- byte_o  out  8  FIFO head byte
- byte_valid_o  out  1  byte_o valid
- byte_ready_i  in  1  consumer takes byte when valid&ready
- spr_we_i  in  1  SPR write strobe
- spr_addr_i  in  1  0: bit count, 1: accumulator
- spr_dat_i  in  32  SPR write data
- spr_dat_o  out  32  SPR read data, combinational on spr_addr_i
- busy_o  out  1  state ≠ RUN or accumulator/FIFO non-empty

## Operation
- Accumulator acc[ACC_W-1:0], left-aligned; bit_cnt = valid bits from MSB.
- States: RUN, PAD, DRAIN, DONE.
- RUN: code_ready_o = (bit_cnt + MAX_CODE_W ≤ ACC_W) and no flush pending. On accept: acc |= masked code << (ACC_W − bit_cnt − size_i), bit_cnt += size_i.
- Extraction (RUN, PAD, DRAIN): if bit_cnt ≥ 8, FIFO not full and no stuff_pending: push acc[ACC_W-1 -: 8], acc <<= 8, bit_cnt −= 8. If pushed byte = 0xFF and stuff_en_i: set stuff_pending; next push is 0x00, which clears it and blocks other extraction that cycle.
- Accept and extract in the same cycle: the shift is applied first, then the code is inserted at the post-shift position (bit_cnt − 8).
- flush_i in RUN → PAD (code_ready_o low from next cycle). PAD: if bit_cnt mod 8 ≠ 0, fill bits to next byte boundary with 1s, bit_cnt rounds up; → DRAIN. DRAIN: extract until bit_cnt = 0, stuff_pending = 0, FIFO empty → DONE. DONE: done_o = 1 for one cycle → RUN.
- flush_i outside RUN is ignored; flush_i with code_valid_i in the same cycle: code is accepted first.
- SPR write in RUN with FIFO empty: addr 0 loads bit_cnt ← spr_dat_i[CNT_W-1:0] (saturated at ACC_W); addr 1 loads acc ← spr_dat_i aligned to MSB. Writes at other times are ignored. Reads: addr 0 → {zero, bit_cnt}; addr 1 → acc[ACC_W-1 -: 32].

## Timing
- Reset values: acc = 0, bit_cnt = 0, state RUN, stuff_pending = 0, FIFO empty, code_ready_o = 1, byte_valid_o = 0, byte_o = 0, done_o = 0, busy_o = 0.
- Code accepted in cycle N → first byte extracted in N+1 → byte_valid_o high in N+2.
- At most one FIFO push and one pop per cycle. Pop and push in the same cycle are allowed when full.
- byte_o/byte_valid_o are held stable while valid & ~ready.
- Reset asserted mid-operation discards all bits and FIFO contents immediately. No done_o is generated.

## Structure
- Package or1200_vlx_pkg: state_t enum (RUN, PAD, DRAIN, DONE), SPR address constants, STUFF_BYTE 8'h00, MARKER_BYTE 8'hFF, PAD_BIT 1'b1.
- Sub-module or1200_vlx_fifo: synchronous byte FIFO, parameter DEPTH, push/pop/full/empty/count, asynchronous active-low reset.

## Test plan
- Codes (0b101, size 3), (0x1F, 5), then flush; byte_ready_i=1 → bytes 0xBF, done_o pulse after last byte.
- Code 0xFF size 8, stuff_en_i=1, then flush → bytes 0xFF, 0x00. Same with stuff_en_i=0 → 0xFF only.
- Size 16 codes 0xFFFF back-to-back, byte_ready_i=0 → FIFO fills, code_ready_o drops at bit_cnt > ACC_W−MAX_CODE_W. Release ready → 0xFF,0x00,0xFF,0x00… with no loss.
- Flush with bit_cnt=3, acc MSBs 0b010 → byte 0x5F; flush with bit_cnt=0 → no bytes, done_o after FIFO drain.
- SPR write addr 0 = 5, addr 1 = 0xA8000000 in RUN; readback matches. Code 0b111 size 3, flush → 0xAF.
- rst_n_i pulled low during DRAIN with 3 bytes queued → byte_valid_o=0 immediately, no done_o, SPR reads return 0.
